// File: rtl/skinny_sbox_layer_ctrl.sv
// Sequences one shared SKINNY-64 Sbox layer through an external, non-stallable
// masked Sbox pipeline: one nibble per randomness word, results written back in issue order.
module skinny_sbox_layer_ctrl #(
    parameter int unsigned NIBBLES = 16,
    parameter int unsigned LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] state_in1,
    input  logic [4*NIBBLES-1:0] state_in2,
    input  logic [4*NIBBLES-1:0] state_in3,
    input  logic [7:0]           rc_cfg,
    input  logic [3:0]           klmn_cfg,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] state_out1,
    output logic [4*NIBBLES-1:0] state_out2,
    output logic [4*NIBBLES-1:0] state_out3,
    input  logic                 rnd_valid,
    input  logic [23:0]          rnd_data,
    output logic                 rnd_ready,
    output logic [3:0]           sb_in1,
    output logic [3:0]           sb_in2,
    output logic [3:0]           sb_in3,
    output logic [23:0]          sb_r,
    output logic [7:0]           sb_rc,
    output logic [3:0]           sb_klmn,
    input  logic [3:0]           sb_out1,
    input  logic [3:0]           sb_out2,
    input  logic [3:0]           sb_out3
);

    localparam int unsigned SW = 4 * NIBBLES;
    localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [SW-1:0]       sh1_q;
    logic [SW-1:0]       sh2_q;
    logic [SW-1:0]       sh3_q;
    logic [7:0]          rc_q;
    logic [CW-1:0]       iss_q;
    logic [CW-1:0]       wr_q;
    logic [LATENCY-1:0]  vpipe_q;
    logic                fire;
    logic                cap;

    assign fire = rnd_valid && rnd_ready;
    assign cap  = vpipe_q[LATENCY-1];

    // Share data only leaves the block on a fire; every other cycle is an all-zero bubble.
    assign sb_in1 = fire ? sh1_q[{iss_q, 2'b00} +: 4] : 4'h0;
    assign sb_in2 = fire ? sh2_q[{iss_q, 2'b00} +: 4] : 4'h0;
    assign sb_in3 = fire ? sh3_q[{iss_q, 2'b00} +: 4] : 4'h0;
    assign sb_r   = fire ? rnd_data : 24'h0;
    assign sb_rc  = fire ? rc_q : 8'h0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ISSUE;
            ISSUE:   if (fire && (iss_q == LAST)) state_d = DRAIN;
            DRAIN:   if (cap && (wr_q == LAST)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rnd_ready <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy      <= (state_d == ISSUE) || (state_d == DRAIN);
            done      <= (state_d == DONE);
            rnd_ready <= (state_d == ISSUE);
        end
    end

    // The valid pipe always shifts: a stall becomes a bubble, never a freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_q <= '0;
        end else begin
            vpipe_q <= (vpipe_q << 1) | LATENCY'(fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh1_q      <= '0;
            sh2_q      <= '0;
            sh3_q      <= '0;
            rc_q       <= '0;
            sb_klmn    <= '0;
            iss_q      <= '0;
            wr_q       <= '0;
            state_out1 <= '0;
            state_out2 <= '0;
            state_out3 <= '0;
        end else if ((state_q == IDLE) && start) begin
            sh1_q   <= state_in1;
            sh2_q   <= state_in2;
            sh3_q   <= state_in3;
            rc_q    <= rc_cfg;
            sb_klmn <= klmn_cfg;
            iss_q   <= '0;
            wr_q    <= '0;
        end else begin
            if (fire) begin
                iss_q <= iss_q + CW'(1);
            end
            if (cap) begin
                state_out1[{wr_q, 2'b00} +: 4] <= sb_out1;
                state_out2[{wr_q, 2'b00} +: 4] <= sb_out2;
                state_out3[{wr_q, 2'b00} +: 4] <= sb_out3;
                wr_q <= wr_q + CW'(1);
            end
            if (state_q == DONE) begin
                sb_klmn <= '0;
            end
        end
    end

endmodule

// File: tb/tb_skinny_sbox_layer_ctrl.sv
// Self-checking bench: a masked 3-stage Sbox model feeds the controller, a
// cycle-level reference model checks every output each cycle, plus literal layer results.
module tb_skinny_sbox_layer_ctrl;

    localparam int unsigned N   = 16;
    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [63:0] state_in1, state_in2, state_in3;
    logic [7:0]  rc_cfg;
    logic [3:0]  klmn_cfg;
    logic        busy, done;
    logic [63:0] state_out1, state_out2, state_out3;
    logic        rnd_valid;
    logic [23:0] rnd_data;
    logic        rnd_ready;
    logic [3:0]  sb_in1, sb_in2, sb_in3;
    logic [23:0] sb_r;
    logic [7:0]  sb_rc;
    logic [3:0]  sb_klmn;
    logic [3:0]  sb_out1, sb_out2, sb_out3;

    int checks = 0;
    int errors = 0;

    skinny_sbox_layer_ctrl #(.NIBBLES(N), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .state_in1(state_in1), .state_in2(state_in2), .state_in3(state_in3),
        .rc_cfg(rc_cfg), .klmn_cfg(klmn_cfg),
        .busy(busy), .done(done),
        .state_out1(state_out1), .state_out2(state_out2), .state_out3(state_out3),
        .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_ready(rnd_ready),
        .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3),
        .sb_r(sb_r), .sb_rc(sb_rc), .sb_klmn(sb_klmn),
        .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC; 4'h1: sbox = 4'h6; 4'h2: sbox = 4'h9; 4'h3: sbox = 4'h0;
            4'h4: sbox = 4'h1; 4'h5: sbox = 4'hA; 4'h6: sbox = 4'h2; 4'h7: sbox = 4'hB;
            4'h8: sbox = 4'h3; 4'h9: sbox = 4'h8; 4'hA: sbox = 4'h5; 4'hB: sbox = 4'hD;
            4'hC: sbox = 4'h4; 4'hD: sbox = 4'hE; 4'hE: sbox = 4'h7; default: sbox = 4'hF;
        endcase
    endfunction

    function automatic logic [3:0] eff(input logic [7:0] rc, input logic [3:0] k);
        eff = rc[3:0] ^ rc[7:4] ^ k;
    endfunction

    function automatic logic [63:0] golden(input logic [63:0] x, input logic [7:0] rc,
                                           input logic [3:0] k);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox(x[4*i +: 4]) ^ eff(rc, k);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Masked Sbox stand-in: unmasked output S(x)^rc^klmn, re-randomised from sb_r.
    logic [3:0]  sx_y, sx_m2, sx_m3;
    logic [11:0] sp [LAT];
    assign sx_y  = sbox(sb_in1 ^ sb_in2 ^ sb_in3) ^ eff(sb_rc, sb_klmn);
    assign sx_m2 = sb_r[3:0] ^ sb_r[15:12];
    assign sx_m3 = sb_r[7:4] ^ sb_r[23:20];
    always @(posedge clk) begin
        sp[0] <= {sx_y ^ sx_m2 ^ sx_m3, sx_m2, sx_m3};
        for (int i = 1; i < LAT; i++) sp[i] <= sp[i-1];
    end
    assign sb_out1 = sp[LAT-1][11:8];
    assign sb_out2 = sp[LAT-1][7:4];
    assign sb_out3 = sp[LAT-1][3:0];

    // Reference model: phase 0 idle, 1 issue, 2 drain, 3 done; in-flight fires kept by fire cycle.
    int          m_phase, m_iss, m_wr, mcyc;
    int          fq[$];
    logic [63:0] m_x1, m_x2, m_x3, m_res;
    logic [7:0]  m_rc;
    logic [3:0]  m_klmn;
    int          ndone = 0, done_prev = 0, done_last = 0;

    initial begin
        bit fire_e, cap_e;
        m_phase = 0; m_iss = 0; m_wr = 0; mcyc = 0;
        m_x1 = '0; m_x2 = '0; m_x3 = '0; m_res = '0; m_rc = '0; m_klmn = '0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (!rst_n) begin
                m_phase = 0; m_iss = 0; m_wr = 0; fq.delete();
                m_x1 = '0; m_x2 = '0; m_x3 = '0; m_res = '0; m_rc = '0; m_klmn = '0;
                chk("reset_ctrl", 64'({busy, done, rnd_ready, sb_klmn, sb_in1, sb_in2, sb_in3}), 64'h0);
                chk("reset_sbr", 64'({sb_r, sb_rc}), 64'h0);
                chk("reset_state_out", state_out1 | state_out2 | state_out3, 64'h0);
            end else begin
                fire_e = (m_phase == 1) && rnd_valid;
                chk("rnd_ready", 64'(rnd_ready), 64'(m_phase == 1));
                chk("busy", 64'(busy), 64'(m_phase == 1 || m_phase == 2));
                chk("done", 64'(done), 64'(m_phase == 3));
                chk("sb_klmn", 64'(sb_klmn), (m_phase == 0) ? 64'h0 : 64'(m_klmn));
                if (fire_e) begin
                    chk("sb_in_shares", 64'({sb_in1, sb_in2, sb_in3}),
                        64'({m_x1[4*m_iss +: 4], m_x2[4*m_iss +: 4], m_x3[4*m_iss +: 4]}));
                    chk("sb_r_rc", 64'({sb_r, sb_rc}), 64'({rnd_data, m_rc}));
                end else begin
                    chk("bubble", 64'({sb_in1, sb_in2, sb_in3, sb_r, sb_rc}), 64'h0);
                end
                chk("unmasked_out", state_out1 ^ state_out2 ^ state_out3, m_res);
                if (done) begin
                    ndone++; done_prev = done_last; done_last = mcyc;
                end
                cap_e = (fq.size() > 0) && (fq[0] + LAT == mcyc);
                if (cap_e) begin
                    void'(fq.pop_front());
                    m_res[4*m_wr +: 4] = sbox(m_x1[4*m_wr +: 4] ^ m_x2[4*m_wr +: 4] ^ m_x3[4*m_wr +: 4])
                                         ^ eff(m_rc, m_klmn);
                    m_wr++;
                end
                if (fire_e) begin
                    fq.push_back(mcyc);
                    m_iss++;
                end
                case (m_phase)
                    0: if (start) begin
                        m_x1 = state_in1; m_x2 = state_in2; m_x3 = state_in3;
                        m_rc = rc_cfg; m_klmn = klmn_cfg; m_iss = 0; m_wr = 0;
                        m_phase = 1;
                    end
                    1: if (fire_e && m_iss == N) m_phase = 2;
                    2: if (cap_e && m_wr == N) m_phase = 3;
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // mode 0: no stalls, 1: stalls in cycles 3,4,9, 2: random stalls.
    task automatic run_layer(input logic [63:0] a1, input logic [63:0] a2, input logic [63:0] a3,
                             input logic [7:0] rc, input logic [3:0] k, input int mode,
                             input bit poke_start, input int rst_cyc,
                             output int done_cyc, output int nstall);
        int issued;
        issued = 0; done_cyc = -1; nstall = 0;
        @(posedge clk); #1;
        start = 1'b1; state_in1 = a1; state_in2 = a2; state_in3 = a3;
        rc_cfg = rc; klmn_cfg = k; rnd_data = 24'($urandom);
        @(posedge clk); #1;
        state_in1 = {$urandom, $urandom}; state_in2 = {$urandom, $urandom};
        state_in3 = {$urandom, $urandom}; rc_cfg = 8'($urandom); klmn_cfg = 4'($urandom);
        for (int c = 1; c <= 80; c++) begin
            bit v;
            v = 1'b1;
            if (mode == 1 && (c == 3 || c == 4 || c == 9)) v = 1'b0;
            if (mode == 2) v = ($urandom_range(0, 3) != 0);
            if (issued < N) begin
                if (v) issued++;
                else nstall++;
            end
            rnd_valid = v;
            rnd_data  = 24'($urandom);
            start     = poke_start && (c == 5);
            rst_n     = (rst_cyc != c);
            @(negedge clk);
            if (done && done_cyc < 0) done_cyc = c;
            if (done_cyc > 0) break;
            if (rst_cyc > 0 && c >= rst_cyc + 25) break;
            @(posedge clk); #1;
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rnd_valid = 1'b1;
            rnd_data  = 24'($urandom);
            @(negedge clk);
        end
    endtask

    localparam logic [63:0] XA = 64'h0123456789ABCDEF;

    initial begin
        int dc, ns, nd0;
        logic [63:0] x, s2, s3;
        rst_n = 1'b0; start = 1'b0;
        state_in1 = '0; state_in2 = '0; state_in3 = '0;
        rc_cfg = '0; klmn_cfg = '0; rnd_valid = 1'b1; rnd_data = '0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(3);

        run_layer(XA, 64'h0, 64'h0, 8'h00, 4'h0, 0, 1'b0, 0, dc, ns);
        chk("latency_plain", 64'(dc), 64'd20);
        chk("result_plain", state_out1 ^ state_out2 ^ state_out3, 64'hC6901A2B385D4E7F);

        run_layer(XA, 64'h0, 64'h0, 8'h00, 4'h0, 1, 1'b0, 0, dc, ns);
        chk("latency_stall", 64'(dc), 64'd23);
        chk("result_stall", state_out1 ^ state_out2 ^ state_out3, 64'hC6901A2B385D4E7F);

        run_layer(XA, 64'h0, 64'h0, 8'hA5, 4'h6, 0, 1'b0, 0, dc, ns);
        chk("latency_rc", 64'(dc), 64'd20);
        chk("result_rc", state_out1 ^ state_out2 ^ state_out3, 64'h5F0983B2A1C4D7E6);
        idle_cycles(2);
        chk("hold_after_done", state_out1 ^ state_out2 ^ state_out3, 64'h5F0983B2A1C4D7E6);

        nd0 = ndone;
        s2 = {$urandom, $urandom}; s3 = {$urandom, $urandom}; x = 64'hFEDCBA9876543210;
        run_layer(x ^ s2 ^ s3, s2, s3, 8'h3C, 4'h9, 0, 1'b1, 0, dc, ns);
        chk("latency_poke", 64'(dc), 64'd20);
        chk("result_poke", state_out1 ^ state_out2 ^ state_out3, golden(x, 8'h3C, 4'h9));
        idle_cycles(4);
        chk("single_done", 64'(ndone - nd0), 64'd1);

        nd0 = ndone;
        run_layer(x, 64'h0, 64'h0, 8'h11, 4'h2, 0, 1'b0, 18, dc, ns);
        chk("reset_no_done", 64'(dc), 64'(-1));
        chk("reset_no_done_cnt", 64'(ndone - nd0), 64'd0);
        run_layer(x, 64'h0, 64'h0, 8'h11, 4'h2, 0, 1'b0, 0, dc, ns);
        chk("latency_after_reset", 64'(dc), 64'd20);
        chk("result_after_reset", state_out1 ^ state_out2 ^ state_out3, golden(x, 8'h11, 4'h2));

        run_layer(XA, 64'h0, 64'h0, 8'h00, 4'h0, 0, 1'b0, 0, dc, ns);
        run_layer(x, 64'h0, 64'h0, 8'h00, 4'h0, 0, 1'b0, 0, dc, ns);
        chk("b2b_spacing", 64'(done_last - done_prev), 64'd21);
        chk("b2b_result", state_out1 ^ state_out2 ^ state_out3, golden(x, 8'h00, 4'h0));

        x = {$urandom, $urandom};
        for (int l = 0; l < 100; l++) begin
            s2 = {$urandom, $urandom}; s3 = {$urandom, $urandom};
            run_layer(x ^ s2 ^ s3, s2, s3, 8'h5A, 4'hC, 2, 1'b0, 0, dc, ns);
            chk("latency_random", 64'(dc), 64'(20 + ns));
            chk("result_random", state_out1 ^ state_out2 ^ state_out3, golden(x, 8'h5A, 4'hC));
        end

        idle_cycles(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
